// File: rtl/hcsr04_pkg.sv
// Shared types and timing constants for the HC-SR04 ultrasonic sensor responder.
// The burst output is only generated when HCSR04_BURST_EN is defined.
package hcsr04_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        BURST,
        ECHO,
        HOLDOFF
    } hcsr04_state_e;

    localparam int unsigned US_PER_CM     = 58;
    localparam int unsigned MAX_CM        = 400;
    localparam int unsigned TIMEOUT_US    = 38000;
    localparam int unsigned BURST_HALF_US = 13;
    localparam int unsigned BURST_TOGGLES = 16;

    // Out-of-range distances behave like a real sensor that hears no return.
    function automatic logic [15:0] echo_ticks(input logic [8:0] cm);
        logic [15:0] ticks;
        if (cm == 9'd0 || cm > 9'(MAX_CM)) begin
            ticks = 16'(TIMEOUT_US);
        end else begin
            ticks = 16'(cm) * 16'(US_PER_CM);
        end
        return ticks;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running prescaler: one clk-wide tick every CLK_PER_US cycles.
module us_tick_gen #(
    parameter int unsigned CLK_PER_US = 100
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int unsigned   CW   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_US - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        tick_d = (cnt_q == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/hcsr04_responder.sv
// HC-SR04 target emulator: answers a Trigger pulse with an Echo pulse encoding distance_cm.
// Define HCSR04_BURST_EN to generate the emulated 40 kHz transducer burst.
module hcsr04_responder
    import hcsr04_pkg::*;
#(
    parameter int unsigned CLK_PER_US  = 100,
    parameter int unsigned TRIG_MIN_US = 10,
    parameter int unsigned BURST_US    = 200,
    parameter int unsigned HOLDOFF_US  = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          Trigger,
    input  logic [8:0]    distance_cm,
    output logic          Echo,
    output logic          busy,
    output logic          burst,
    output hcsr04_state_e state_dbg_o
);

    logic tick;

    us_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    logic          trig_s1_q, trig_s2_q, trig_prev_q;
    logic          trig_rise, trig_fall;
    hcsr04_state_e state_q, state_d;
    logic [7:0]    width_q, width_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [8:0]    cm_q, cm_d;
    logic          echo_q, echo_d;
    logic          busy_q, busy_d;

    assign trig_rise = trig_s2_q & ~trig_prev_q;
    assign trig_fall = ~trig_s2_q & trig_prev_q;

    // Edges seen outside IDLE/TRIG simply fall through the case with no effect.
    always_comb begin
        state_d = state_q;
        width_d = width_q;
        cnt_d   = cnt_q;
        cm_d    = cm_q;
        unique case (state_q)
            IDLE: begin
                if (trig_rise) begin
                    state_d = TRIG;
                    width_d = '0;
                end
            end
            TRIG: begin
                if (tick && width_q != 8'hFF) width_d = width_q + 8'd1;
                if (trig_fall) begin
                    if (width_d >= 8'(TRIG_MIN_US)) begin
                        state_d = BURST;
                        cm_d    = distance_cm;
                        cnt_d   = 16'(BURST_US);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            BURST: begin
                if (tick) begin
                    if (cnt_q <= 16'd1) begin
                        state_d = ECHO;
                        cnt_d   = echo_ticks(cm_q);
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
            end
            ECHO: begin
                if (tick) begin
                    if (cnt_q <= 16'd1) begin
                        state_d = HOLDOFF;
                        cnt_d   = 16'(HOLDOFF_US);
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
            end
            HOLDOFF: begin
                if (tick) begin
                    if (cnt_q <= 16'd1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        echo_d = (state_d == ECHO);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_s1_q   <= 1'b0;
            trig_s2_q   <= 1'b0;
            trig_prev_q <= 1'b0;
            state_q     <= IDLE;
            width_q     <= '0;
            cnt_q       <= '0;
            cm_q        <= '0;
            echo_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            trig_s1_q   <= Trigger;
            trig_s2_q   <= trig_s1_q;
            trig_prev_q <= trig_s2_q;
            state_q     <= state_d;
            width_q     <= width_d;
            cnt_q       <= cnt_d;
            cm_q        <= cm_d;
            echo_q      <= echo_d;
            busy_q      <= busy_d;
        end
    end

    assign Echo        = echo_q;
    assign busy        = busy_q;
    assign state_dbg_o = state_q;

`ifdef HCSR04_BURST_EN
    logic       burst_q, burst_d;
    logic [3:0] half_q, half_d;
    logic [4:0] ntog_q, ntog_d;

    // First toggle lands on BURST entry; after 16 toggles the line rests low.
    always_comb begin
        burst_d = burst_q;
        half_d  = half_q;
        ntog_d  = ntog_q;
        if (state_d != BURST) begin
            burst_d = 1'b0;
            half_d  = '0;
            ntog_d  = '0;
        end else if (state_q != BURST) begin
            burst_d = 1'b1;
            half_d  = '0;
            ntog_d  = 5'd1;
        end else if (tick && ntog_q < 5'(BURST_TOGGLES)) begin
            if (half_q == 4'(BURST_HALF_US - 1)) begin
                half_d  = '0;
                burst_d = ~burst_q;
                ntog_d  = ntog_q + 5'd1;
            end else begin
                half_d = half_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q <= 1'b0;
            half_q  <= '0;
            ntog_q  <= '0;
        end else begin
            burst_q <= burst_d;
            half_q  <= half_d;
            ntog_q  <= ntog_d;
        end
    end

    assign burst = burst_q;
`else
    assign burst = 1'b0;
`endif

endmodule
